// File: rtl/div_ctrl.sv
// div_ctrl: sequences a multi-cycle external divider for DIV/DIVU/REM/REMU.
// Launches the divide, holds the pipeline, and produces one writeback pulse
// when the divider reports ready.
// Optional build macro DIV_TIMEOUT_EN adds a 48-cycle ISSUE watchdog that
// aborts a hung divide and pulses err_o. Without the macro, err_o is tied to 0.
module div_ctrl (
    input  logic        clk,
    input  logic        rstn,
    input  logic        inst_valid_i,
    input  logic [2:0]  op_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        flush_i,
    output logic        div_start_o,
    output logic [31:0] div_dividend_o,
    output logic [31:0] div_divisor_o,
    output logic [2:0]  div_op_o,
    output logic [4:0]  div_reg_waddr_o,
    input  logic [31:0] div_result_i,
    input  logic        div_ready_i,
    input  logic        div_busy_i,
    output logic        stall_o,
    output logic        reg_we_o,
    output logic [4:0]  reg_waddr_o,
    output logic [31:0] reg_wdata_o,
    output logic        err_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] dividend_q, dividend_d;
    logic [31:0] divisor_q, divisor_d;
    logic [2:0]  op_q, op_d;
    logic [4:0]  rd_q, rd_d;

    // Unmasked versions of the outputs; masked to zero while rstn is low.
    logic        start_c;
    logic [31:0] dividend_c;
    logic [31:0] divisor_c;
    logic [2:0]  op_c;
    logic [4:0]  div_waddr_c;
    logic        stall_c;
    logic        we_c;
    logic [4:0]  waddr_c;
    logic [31:0] wdata_c;
    logic        err_c;

    logic        timeout;

`ifdef DIV_TIMEOUT_EN
    localparam logic [5:0] TMO_LIMIT = 6'd48;

    logic [5:0] tmo_cnt_q, tmo_cnt_d;

    assign timeout = (state_q == ISSUE) && (tmo_cnt_q == TMO_LIMIT);

    // Watchdog counter: cleared on ISSUE entry, counts ISSUE cycles without ready.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tmo_cnt_q <= 6'd0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Next-state and output decode. Everything toward the divider and the
    // register file is combinational so start drops in the ready cycle itself.
    always_comb begin
        state_d     = state_q;
        dividend_d  = dividend_q;
        divisor_d   = divisor_q;
        op_d        = op_q;
        rd_d        = rd_q;
        start_c     = 1'b0;
        dividend_c  = 32'd0;
        divisor_c   = 32'd0;
        op_c        = 3'd0;
        div_waddr_c = 5'd0;
        stall_c     = 1'b0;
        we_c        = 1'b0;
        waddr_c     = 5'd0;
        wdata_c     = 32'd0;
        err_c       = 1'b0;
`ifdef DIV_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (inst_valid_i && !flush_i) begin
                    stall_c = 1'b1;
                    if (!div_busy_i) begin
                        // Launch straight from the inputs and remember them.
                        start_c     = 1'b1;
                        dividend_c  = rs1_data_i;
                        divisor_c   = rs2_data_i;
                        op_c        = op_i;
                        div_waddr_c = rd_addr_i;
                        dividend_d  = rs1_data_i;
                        divisor_d   = rs2_data_i;
                        op_d        = op_i;
                        rd_d        = rd_addr_i;
                        state_d     = ISSUE;
`ifdef DIV_TIMEOUT_EN
                        tmo_cnt_d   = 6'd0;
`endif
                    end else begin
                        // Divider still owned by an earlier (aborted) operation.
                        state_d = DRAIN;
                    end
                end
            end

            ISSUE: begin
                dividend_c  = dividend_q;
                divisor_c   = divisor_q;
                op_c        = op_q;
                div_waddr_c = rd_q;
                if (flush_i) begin
                    state_d = IDLE;
                end else if (timeout) begin
                    err_c   = 1'b1;
                    state_d = IDLE;
                end else if (div_ready_i) begin
                    // x0 is never written; address/data stay 0 without a write.
                    if (rd_q != 5'd0) begin
                        we_c    = 1'b1;
                        waddr_c = rd_q;
                        wdata_c = div_result_i;
                    end
                    state_d = IDLE;
                end else begin
                    start_c = 1'b1;
                    stall_c = 1'b1;
`ifdef DIV_TIMEOUT_EN
                    tmo_cnt_d = tmo_cnt_q + 6'd1;
`endif
                end
            end

            DRAIN: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else begin
                    stall_c = 1'b1;
                    if (!div_busy_i) begin
                        state_d = IDLE;
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and captured-operand registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            dividend_q <= 32'd0;
            divisor_q  <= 32'd0;
            op_q       <= 3'd0;
            rd_q       <= 5'd0;
        end else begin
            state_q    <= state_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            op_q       <= op_d;
            rd_q       <= rd_d;
        end
    end

    // While reset is asserted every output is forced low, including the
    // combinational paths from the instruction inputs.
    assign div_start_o     = rstn & start_c;
    assign div_dividend_o  = {32{rstn}} & dividend_c;
    assign div_divisor_o   = {32{rstn}} & divisor_c;
    assign div_op_o        = {3{rstn}} & op_c;
    assign div_reg_waddr_o = {5{rstn}} & div_waddr_c;
    assign stall_o         = rstn & stall_c;
    assign reg_we_o        = rstn & we_c;
    assign reg_waddr_o     = {5{rstn}} & waddr_c;
    assign reg_wdata_o     = {32{rstn}} & wdata_c;
    assign err_o           = rstn & err_c;

endmodule

// File: doc/div_ctrl.md
DIV_CTRL -- requirements
Module: div_ctrl

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rstn  input  1  asynchronous active-low reset.
REQ-003 SHALL have ports: inst_valid_i  input  1  EX holds a DIV/DIVU/REM/REMU instruction; op_i  input  3  funct3 (100 DIV, 101 DIVU, 110 REM, 111 REMU).
REQ-004 SHALL have ports: rs1_data_i, rs2_data_i  input  32  dividend, divisor; rd_addr_i  input  5  destination register; flush_i  input  1  pipeline flush.
REQ-005 SHALL have ports to divider: div_start_o  output  1; div_dividend_o, div_divisor_o  output  32; div_op_o  output  3; div_reg_waddr_o  output  5.
REQ-006 SHALL have ports from divider: div_result_i  input  32; div_ready_i  input  1 (one-cycle pulse); div_busy_i  input  1.
REQ-007 SHALL have ports: stall_o  output  1  hold PC/IF/ID/EX; reg_we_o  output  1; reg_waddr_o  output  5; reg_wdata_o  output  32; err_o  output  1  timeout pulse.

Function
REQ-008 SHALL implement states IDLE, ISSUE, DRAIN; only IDLE accepts an instruction.
REQ-009 IDLE: inst_valid_i=1, flush_i=0, div_busy_i=0 -> div_start_o=1 combinationally, operand/op/rd outputs driven straight from inputs, same values captured into registers, next state ISSUE.
REQ-010 IDLE: inst_valid_i=1, flush_i=0, div_busy_i=1 -> div_start_o=0, stall_o=1, next state DRAIN; DRAIN returns to IDLE the first cycle div_busy_i=0.
REQ-011 ISSUE: div_start_o=1 held continuously with captured operands/op/rd until div_ready_i=1 or abort; divider latency is not assumed fixed.
REQ-012 ISSUE with div_ready_i=1, flush_i=0 -> div_start_o=0 in that same cycle (combinational, so the divider does not relaunch), reg_we_o=(captured rd != 0), reg_waddr_o=captured rd, reg_wdata_o=div_result_i, stall_o=0, next state IDLE.
REQ-013 stall_o=1 in IDLE with accepted/blocked instruction, in DRAIN, and in ISSUE while div_ready_i=0; 0 otherwise.
REQ-014 flush_i=1 has priority: IDLE -> no start; ISSUE/DRAIN -> div_start_o=0 that cycle, no writeback even if div_ready_i=1, stall_o=0, next state IDLE.
REQ-015 Back-to-back divides SHALL incur exactly one cycle with div_start_o=0 (the ready cycle) between operations.
REQ-016 reg_we_o SHALL be a single-cycle pulse; reg_waddr_o/reg_wdata_o SHALL be 0 when reg_we_o=0.
REQ-017 Captured operands SHALL not change while in ISSUE regardless of rs1/rs2 input activity.

Reset
REQ-018 rstn=0 SHALL asynchronously force IDLE, clear captured registers and timeout counter; all outputs 0 while in reset.
REQ-019 Reset mid-ISSUE SHALL drop div_start_o immediately; no writeback generated for the aborted divide.

Configuration
REQ-020 Macro DIV_TIMEOUT_EN defined: 6-bit counter clears on entry to ISSUE, increments each ISSUE cycle without div_ready_i; at count 48 -> div_start_o=0, err_o=1 one cycle, no writeback, stall_o=0, next state IDLE.
REQ-021 Macro DIV_TIMEOUT_EN undefined: no counter logic, err_o tied 0, ISSUE waits for div_ready_i indefinitely.

Verification
REQ-022 DIV 100/-7, rd=5, bench divider -> start held until ready, single writeback x5=0xFFFFFFF2, stall_o falls in ready cycle.
REQ-023 DIVU 7/0, rd=3 -> ready 2 cycles after start, x3=0xFFFFFFFF; REM 7/0 -> 7.
REQ-024 DIV then REM back-to-back on 0x80000000/-1 -> x_rd=0x80000000 then 0, exactly one start-low cycle between them.
REQ-025 flush_i at cycle 10 of ISSUE -> start low that cycle, no reg_we_o, next divide starts cleanly and returns correct value.
REQ-026 rd=0 -> divide runs, stall released on ready, reg_we_o stays 0.
REQ-027 DIV_TIMEOUT_EN with divider model never asserting ready -> err_o pulse after 48 ISSUE cycles, stall_o=0, no writeback.
